rps_match_referee: RTL
======================

// Module: rps_match_referee
// PURPOSE
//  Sequential best-of-N rock-paper-scissors referee and the successor to the single-round checker.
//  Each round, it collects one move from each of two players through a valid/ready handshake.
//  It judges each round, keeps the scores and declares the match winner when a player reaches WIN_TARGET or MAX_ROUNDS expire.
//  It sits between the player input front-ends and the score display / host status logic.
// PARAMETERS
//  WIN_TARGET  3   round wins needed to take the match (1..2**SCORE_W-1)
//  MAX_ROUNDS  9   judged (non-void) rounds before forced match end (>= 2*WIN_TARGET-1)
//  SCORE_W     4   width of score_a/score_b/rounds counters
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        asynchronous, active-high reset
//  start         in   1        begin a new match (honoured in IDLE and DONE only)
//  a_valid       in   1        player A move offered
//  a_move        in   3        one-hot: 001 rock, 010 paper, 100 scissors
//  a_ready       out  1        referee accepts A's move this cycle
//  b_valid       in   1        player B move offered
//  b_move        in   3        one-hot, same encoding
//  b_ready       out  1        referee accepts B's move this cycle
//  round_valid   out  1        1-cycle pulse: round_result is meaningful
//  round_result  out  2        00 tie, 01 A wins, 10 B wins, 11 void (invalid move)
//  score_a       out  SCORE_W  A round wins this match
//  score_b       out  SCORE_W  B round wins this match
//  rounds        out  SCORE_W  judged rounds this match (ties count, voids do not)
//  busy          out  1        match in progress (COLLECT or JUDGE)
//  match_done    out  1        level, high in DONE
//  match_winner  out  2        00 none/draw, 01 A, 10 B; valid while match_done
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; all outputs 0; move holding regs cleared.
//  - FSM IDLE -> (start) COLLECT -> (both moves held) JUDGE -> COLLECT | DONE -> (start) COLLECT.
//  - a_ready = (state==COLLECT) && !a_held; a move latches on the edge where a_valid&&a_ready; b_ready likewise.
//  - Each player submits exactly one move per round; while held, ready=0 and further valids are ignored.
//  - Both moves may latch on the same edge. The edge that sets the second held flag moves the FSM to JUDGE.
//  - JUDGE lasts exactly 1 cycle: round_valid=1 and round_result is driven from the held moves.
//    Latency: 1 cycle from the accepting edge of the second move to round_valid.
//  - Void: either held move not one-hot (000, 011, 111, ...) -> result 11; no score or rounds change; back to COLLECT.
//  - Otherwise, on the JUDGE exit edge: rounds+=1; winner's score+=1 (paper>rock, rock>scissors, scissors>paper; equal=tie).
//    Held flags clear on the same edge.
//  - Match end (evaluated with post-update values on the JUDGE exit edge):
//    score==WIN_TARGET -> DONE with that winner. Else rounds==MAX_ROUNDS -> DONE; higher score wins, equal -> 00.
//  - Scores never exceed WIN_TARGET, so there is no counter wrap.
//  - DONE: scores, rounds and match_winner hold; ready=0. start clears the scores, rounds and held flags, then -> COLLECT.
//  - start in COLLECT/JUDGE is ignored.
//  - A valid asserted in IDLE/DONE is dropped (not latched).
//  - Reset mid-round discards held moves and scores.
//  - match_done = (state==DONE); busy = (state==COLLECT||state==JUDGE).
// STRUCTURE
//  - rps_pkg: move_t enum (ROCK=3'b001, PAPER=3'b010, SCISSORS=3'b100); result_t enum (TIE, A_WIN, B_WIN, VOID);
//    state_t enum (IDLE, COLLECT, JUDGE, DONE).
//  - Sub-module rps_round_judge: pure combinational (a_move, b_move) -> result_t, including the one-hot check.
//  - The top level holds the FSM, handshake registers and counters.
// TESTING (WIN_TARGET=2, MAX_ROUNDS=3 unless noted)
//  1 start; A=001, B=100 same cycle -> round_valid 1 cycle later, result 01, score_a=1; A=010, B=001 -> result 01,
//    score_a=2, match_done=1, match_winner=01.
//  2 A=100 at cycle t, B=100 at t+4 -> a_ready low t+1..t+4, result 00, rounds=1, scores 0/0;
//    A re-asserts valid while held -> ignored.
//  3 A=011, B=001 -> result 11, rounds/scores unchanged, a_ready and b_ready high the next cycle.
//  4 tie, A win, B win (3 judged rounds) -> DONE at rounds=3, score 1/1, match_winner=00.
//  5 reset asserted while A's move is held -> all outputs 0 immediately (async), IDLE; start -> fresh match, scores 0.
//  6 in DONE: valids ignored, start in the same cycle as a_valid -> scores cleared, a_ready high the following cycle;
//    start in COLLECT has no effect.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors match referee.
package rps_pkg;

    typedef enum logic [2:0] {
        ROCK     = 3'b001,
        PAPER    = 3'b010,
        SCISSORS = 3'b100
    } move_t;

    typedef enum logic [1:0] {
        TIE   = 2'b00,
        A_WIN = 2'b01,
        B_WIN = 2'b10,
        VOID  = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        JUDGE,
        DONE
    } state_t;

    // A move is legal only if it is exactly one of the three encodings.
    function automatic logic is_legal_move(input logic [2:0] m);
        return (m == ROCK) || (m == PAPER) || (m == SCISSORS);
    endfunction

endpackage

// File: rtl/rps_round_judge.sv
// Combinational judge for one round: two held moves in, round outcome out.
module rps_round_judge
    import rps_pkg::*;
(
    input  logic [2:0] a_move,
    input  logic [2:0] b_move,
    output logic [1:0] result
);

    // Void takes priority over any win/tie decision.
    always_comb begin
        result = B_WIN;
        if (!is_legal_move(a_move) || !is_legal_move(b_move)) begin
            result = VOID;
        end else if (a_move == b_move) begin
            result = TIE;
        end else if ((a_move == PAPER    && b_move == ROCK)     ||
                     (a_move == ROCK     && b_move == SCISSORS) ||
                     (a_move == SCISSORS && b_move == PAPER)) begin
            result = A_WIN;
        end
    end

endmodule

// File: rtl/rps_match_referee.sv
// Best-of-N rock-paper-scissors referee: collects one move per player per
// round via valid/ready, judges, keeps scores and declares the match winner.
module rps_match_referee
    import rps_pkg::*;
#(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 9,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               a_valid,
    input  logic [2:0]         a_move,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic [2:0]         b_move,
    output logic               b_ready,
    output logic               round_valid,
    output logic [1:0]         round_result,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [SCORE_W-1:0] rounds,
    output logic               busy,
    output logic               match_done,
    output logic [1:0]         match_winner
);

    localparam logic [SCORE_W-1:0] WIN_CNT   = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] ROUND_CNT = SCORE_W'(MAX_ROUNDS);
    localparam logic [SCORE_W-1:0] ONE       = SCORE_W'(1);

    state_t             state, state_nx;
    logic               a_held, a_held_nx, b_held, b_held_nx;
    logic [2:0]         a_hold, a_hold_nx, b_hold, b_hold_nx;
    logic [SCORE_W-1:0] sa, sa_nx, sb, sb_nx, rc, rc_nx;
    logic [1:0]         winner, winner_nx;
    logic [1:0]         judge_result;
    logic               a_take, b_take;

    rps_round_judge u_judge (
        .a_move (a_hold),
        .b_move (b_hold),
        .result (judge_result)
    );

    assign a_ready      = (state == COLLECT) && !a_held;
    assign b_ready      = (state == COLLECT) && !b_held;
    assign a_take       = a_valid && a_ready;
    assign b_take       = b_valid && b_ready;
    assign round_valid  = (state == JUDGE);
    assign round_result = round_valid ? judge_result : 2'b00;
    assign score_a      = sa;
    assign score_b      = sb;
    assign rounds       = rc;
    assign busy         = (state == COLLECT) || (state == JUDGE);
    assign match_done   = (state == DONE);
    assign match_winner = winner;

    // State, handshake holding registers and match counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_held <= 1'b0;
            b_held <= 1'b0;
            a_hold <= '0;
            b_hold <= '0;
            sa     <= '0;
            sb     <= '0;
            rc     <= '0;
            winner <= '0;
        end else begin
            state  <= state_nx;
            a_held <= a_held_nx;
            b_held <= b_held_nx;
            a_hold <= a_hold_nx;
            b_hold <= b_hold_nx;
            sa     <= sa_nx;
            sb     <= sb_nx;
            rc     <= rc_nx;
            winner <= winner_nx;
        end
    end

    // Next-state, move capture, scoring and match-end decision.
    always_comb begin
        state_nx  = state;
        a_held_nx = a_held;
        b_held_nx = b_held;
        a_hold_nx = a_hold;
        b_hold_nx = b_hold;
        sa_nx     = sa;
        sb_nx     = sb;
        rc_nx     = rc;
        winner_nx = winner;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    sa_nx     = '0;
                    sb_nx     = '0;
                    rc_nx     = '0;
                    a_held_nx = 1'b0;
                    b_held_nx = 1'b0;
                    winner_nx = '0;
                    state_nx  = COLLECT;
                end
            end
            COLLECT: begin
                if (a_take) begin
                    a_held_nx = 1'b1;
                    a_hold_nx = a_move;
                end
                if (b_take) begin
                    b_held_nx = 1'b1;
                    b_hold_nx = b_move;
                end
                if ((a_held || a_take) && (b_held || b_take)) begin
                    state_nx = JUDGE;
                end
            end
            JUDGE: begin
                a_held_nx = 1'b0;
                b_held_nx = 1'b0;
                state_nx  = COLLECT;
                if (judge_result != VOID) begin
                    rc_nx = rc + ONE;
                    if (judge_result == A_WIN) sa_nx = sa + ONE;
                    if (judge_result == B_WIN) sb_nx = sb + ONE;
                    // Match end uses the post-update counts.
                    if (sa_nx == WIN_CNT) begin
                        state_nx  = DONE;
                        winner_nx = 2'b01;
                    end else if (sb_nx == WIN_CNT) begin
                        state_nx  = DONE;
                        winner_nx = 2'b10;
                    end else if (rc_nx == ROUND_CNT) begin
                        state_nx = DONE;
                        if (sa_nx > sb_nx)      winner_nx = 2'b01;
                        else if (sb_nx > sa_nx) winner_nx = 2'b10;
                        else                    winner_nx = 2'b00;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
